// File: rtl/fetch_queue.sv
// Instruction fetch front end: single-outstanding icache requests feeding a {pc, inst} FIFO to decode.
// Optional macro FETCH_QUEUE_BYPASS_EN forwards a response straight to decode when the queue is empty.
module fetch_queue #(
  parameter int unsigned DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic [3:0]  imem_rmask,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  output logic        deq_valid,
  input  logic        deq_ready,
  output logic [31:0] deq_inst,
  output logic [31:0] deq_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);
  localparam int unsigned PW = $clog2(DEPTH);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t        state_reg, state_next;
  logic [31:0]   fetch_pc_reg, req_pc_reg, addr_reg;
  logic [3:0]    rmask_reg;
  logic          discard_reg, discard_next;
  logic [PW-1:0] head_reg, tail_reg;
  logic [PW:0]   count_reg, count_next, occupancy;
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];

  logic outstanding, outstanding_after_resp, accept, bypass_hit;
  logic wr_en, rd_en, issue;

  assign outstanding            = (state_reg == WAIT);
  assign outstanding_after_resp = outstanding && !imem_resp;
  assign accept                 = imem_resp && !discard_reg && !redirect_valid;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass_hit = accept && (count_reg == '0);
  assign deq_pc     = bypass_hit ? req_pc_reg : pc_mem[head_reg];
  assign deq_inst   = bypass_hit ? imem_rdata : inst_mem[head_reg];
`else
  assign bypass_hit = 1'b0;
  assign deq_pc     = pc_mem[head_reg];
  assign deq_inst   = inst_mem[head_reg];
`endif

  assign deq_valid = !redirect_valid && ((count_reg != '0) || bypass_hit);
  assign rd_en     = deq_valid && deq_ready && (count_reg != '0);
  assign wr_en     = accept && !(bypass_hit && deq_ready);

  // The retiring response already owns a slot, so throttle on queue plus incoming write.
  assign occupancy = count_reg + {{PW{1'b0}}, wr_en};
  assign issue     = !rst && !redirect_valid && !outstanding_after_resp &&
                     (occupancy < (PW+1)'(DEPTH));

  assign imem_addr  = addr_reg;
  assign imem_rmask = rmask_reg;

  always_comb begin
    state_next   = state_reg;
    discard_next = discard_reg;
    count_next   = count_reg;
    if (issue)
      state_next = WAIT;
    else if (imem_resp)
      state_next = IDLE;
    if (imem_resp)
      discard_next = 1'b0;
    if (redirect_valid) begin
      count_next = '0;
      if (outstanding_after_resp)
        discard_next = 1'b1;
    end else begin
      count_next = count_reg + {{PW{1'b0}}, wr_en} - {{PW{1'b0}}, rd_en};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      discard_reg  <= 1'b0;
      fetch_pc_reg <= RESET_PC;
      req_pc_reg   <= RESET_PC;
      addr_reg     <= RESET_PC;
      rmask_reg    <= 4'h0;
      head_reg     <= '0;
      tail_reg     <= '0;
      count_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      discard_reg <= discard_next;
      count_reg   <= count_next;
      rmask_reg   <= issue ? 4'hf : 4'h0;
      if (redirect_valid) begin
        fetch_pc_reg <= {redirect_pc[31:2], 2'b00};
        head_reg     <= '0;
        tail_reg     <= '0;
      end else begin
        if (issue) begin
          addr_reg     <= fetch_pc_reg;
          req_pc_reg   <= fetch_pc_reg;
          fetch_pc_reg <= fetch_pc_reg + 32'd4;
        end
        if (wr_en)
          tail_reg <= tail_reg + PW'(1);
        if (rd_en)
          head_reg <= head_reg + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      pc_mem[tail_reg]   <= req_pc_reg;
      inst_mem[tail_reg] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: icache responder model, fetch-PC model and in-order dequeue checks.
module tb_fetch_queue;
  localparam logic [31:0] RESET_PC = 32'h1eceb000;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic        clk, rst;
  logic [31:0] imem_addr, imem_rdata, deq_inst, deq_pc, redirect_pc;
  logic [3:0]  imem_rmask;
  logic        imem_resp, deq_valid, deq_ready, redirect_valid;

  fetch_queue #(.DEPTH(8), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_rmask(imem_rmask),
    .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .deq_valid(deq_valid), .deq_ready(deq_ready),
    .deq_inst(deq_inst), .deq_pc(deq_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_tests = 0, n_fail = 0;
  int          cyc = 0, lat = 1;
  int          n_req, n_resp, n_deq, n_drop;
  bit          ready_cfg, redir_cfg, redir_on_resp, fired, track_first, req_now;
  logic [31:0] redir_pc_cfg, exp_fetch_pc, last_req_addr, first_deq_pc;
  logic [31:0] req_q [$];
  int          seen_q [$];
  bit          stale_q [$];
  ent_t        sb [$];

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {pc[15:0], pc[31:16]} ^ 32'h0000_0013;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: observe requests, drive responder/decode/redirect, then check the dequeue side.
  task automatic step();
    bit          had_req, stale_now, redir_now, exp_valid;
    logic [31:0] rpc;
    ent_t        e;
    @(posedge clk); #1;
    cyc++;
    req_now = 1'b0;
    if (!rst && imem_rmask != 4'h0) begin
      check("req_rmask", {28'd0, imem_rmask}, 32'hf);
      check("req_addr", imem_addr, exp_fetch_pc);
      exp_fetch_pc += 32'd4;
      req_q.push_back(imem_addr);
      seen_q.push_back(cyc);
      stale_q.push_back(1'b0);
      n_req++;
      req_now = 1'b1;
      last_req_addr = imem_addr;
      $display("[TB] cycle %0d request addr=%h", cyc, imem_addr);
    end
    imem_resp = 1'b0;
    stale_now = 1'b0;
    rpc       = '0;
    had_req   = (req_q.size() > 0);
    if (!rst && had_req && (seen_q[0] + lat <= cyc)) begin
      rpc = req_q.pop_front();
      void'(seen_q.pop_front());
      stale_now  = stale_q.pop_front();
      imem_resp  = 1'b1;
      imem_rdata = inst_of(rpc);
      if (stale_now) n_drop++;
    end
    assert (!imem_resp || had_req);
    redir_now      = !rst && (redir_cfg || (redir_on_resp && imem_resp && sb.size() == 3));
    redirect_valid = redir_now;
    redirect_pc    = redir_pc_cfg;
    deq_ready      = rst ? 1'b0 : ready_cfg;
    exp_valid      = !redir_now &&
                     ((sb.size() > 0) || (BYP && imem_resp && !stale_now && sb.size() == 0));
    if (redir_now) begin
      sb.delete();
      foreach (stale_q[i]) stale_q[i] = 1'b1;
      exp_fetch_pc = {redir_pc_cfg[31:2], 2'b00};
      fired        = 1'b1;
      track_first  = 1'b1;
    end else if (imem_resp && !stale_now) begin
      sb.push_back('{rpc, inst_of(rpc)});
      n_resp++;
    end
    #1;
    if (!rst) begin
      check("deq_valid", {31'd0, deq_valid}, {31'd0, exp_valid});
      if (deq_valid && deq_ready) begin
        if (sb.size() == 0) begin
          check("deq_unexpected", {31'd0, deq_valid}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("deq_pc", deq_pc, e.pc);
          check("deq_inst", deq_inst, e.inst);
          n_deq++;
          if (track_first) first_deq_pc = deq_pc;
          track_first = 1'b0;
          $display("[TB] cycle %0d dequeue pc=%h inst=%h", cyc, deq_pc, deq_inst);
        end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; imem_resp = 1'b0; imem_rdata = '0; deq_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    ready_cfg = 1'b0; redir_cfg = 1'b0; redir_on_resp = 1'b0; fired = 1'b0; track_first = 1'b0;
    req_q.delete(); seen_q.delete(); stale_q.delete(); sb.delete();
    n_req = 0; n_resp = 0; n_deq = 0; n_drop = 0;
    exp_fetch_pc = RESET_PC; first_deq_pc = 32'hdeadbeef; lat = 1;
    repeat (3) step();
    check("rst_rmask", {28'd0, imem_rmask}, 32'd0);
    check("rst_addr", imem_addr, RESET_PC);
    check("rst_deq_valid", {31'd0, deq_valid}, 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    int          k;
    logic [31:0] wrap_addr [2];

    // Streaming with decode always ready.
    do_reset();
    ready_cfg = 1'b1;
    step();
    check("first_req", {28'd0, imem_rmask}, 32'hf);
    repeat (40) step();
    check("t1_deq_enough", {31'd0, (n_deq >= 15)}, 32'd1);

    // Decode stalled: queue fills to DEPTH, then one dequeue lets one more request out.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      step();
      if (deq_valid) check("t2_deq_pc", deq_pc, RESET_PC);
    end
    check("t2_resp", n_resp, 32'd8);
    check("t2_req", n_req, 32'd8);
    ready_cfg = 1'b1; step(); ready_cfg = 1'b0;
    repeat (6) step();
    check("t2_req_after_deq", n_req, 32'd9);
    ready_cfg = 1'b1;
    repeat (40) step();

    // Redirect while the request to 0x1eceb00c is still outstanding.
    do_reset();
    ready_cfg = 1'b1; lat = 3;
    for (int i = 0; i < 60; i++) begin
      step();
      if (req_now && last_req_addr == 32'h1eceb00c) break;
    end
    check("t3_saw_req", last_req_addr, 32'h1eceb00c);
    redir_pc_cfg = 32'h00001000; redir_cfg = 1'b1; step(); redir_cfg = 1'b0;
    repeat (30) step();
    check("t3_first_pc", first_deq_pc, 32'h00001000);
    check("t3_dropped", n_drop, 32'd1);

    // Redirect coinciding with a response while 3 entries are queued.
    do_reset();
    redir_pc_cfg = 32'h00002003; redir_on_resp = 1'b1;
    for (int i = 0; i < 60 && !fired; i++) step();
    redir_on_resp = 1'b0;
    check("t4_fired", {31'd0, fired}, 32'd1);
    req_now = 1'b0;
    for (int i = 0; i < 20 && !req_now; i++) step();
    check("t4_next_req", last_req_addr, 32'h00002000);
    ready_cfg = 1'b1;
    repeat (20) step();
    check("t4_first_pc", first_deq_pc, 32'h00002000);

    // Redirect to the top of the address space: fetch must wrap to 0.
    do_reset();
    ready_cfg = 1'b1;
    repeat (6) step();
    redir_pc_cfg = 32'hfffffffc; redir_cfg = 1'b1; step(); redir_cfg = 1'b0;
    k = 0;
    wrap_addr[0] = 32'hdeadbeef; wrap_addr[1] = 32'hdeadbeef;
    for (int i = 0; i < 30 && k < 2; i++) begin
      step();
      if (req_now) begin
        wrap_addr[k] = last_req_addr;
        k++;
      end
    end
    check("t5_nreq", k, 32'd2);
    check("t5_addr0", wrap_addr[0], 32'hfffffffc);
    check("t5_addr1", wrap_addr[1], 32'h00000000);
    repeat (10) step();
    check("t5_first_pc", first_deq_pc, 32'hfffffffc);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
